// File: rtl/piso_pkg.sv
// piso_pkg: shared FSM state type and counter-width helper for the serializer
package piso_pkg;
    typedef enum logic {IDLE, SHIFT} state_e;
    // bit counter width: max(1, clog2(w))
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/piso_if.sv
// piso_if: load handshake, shift enable and serial outputs of the serializer
// master (testbench side) drives load_valid, load_data and shift_en.
// slave (serializer) drives load_ready, ser_out, ser_valid, busy and frame_done.
interface piso_if #(parameter int WIDTH = 8);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             shift_en;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             frame_done;
    modport master (output load_valid, load_data, shift_en,
                    input  load_ready, ser_out, ser_valid, busy, frame_done);
    modport slave  (input  load_valid, load_data, shift_en,
                    output load_ready, ser_out, ser_valid, busy, frame_done);
endinterface

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: frame bit-position counter with clear priority and terminal-count flag
// Ports: clk, rst (sync, active high), en (advance), clr (back to 0), tc (count == WIDTH-1).
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // saturates at LAST so the count never exceeds WIDTH-1
    always_comb cnt_d = clr ? '0 : (en && !tc) ? cnt_q + CW'(1) : cnt_q;
    assign tc = cnt_q == LAST;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with ready/valid load and gapless back-to-back frames
// Ports: clk, rst (sync, active high), bus (piso_if slave: load handshake, shift_en,
// ser_out, ser_valid, busy, frame_done).
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1,
    parameter bit IDLE_LEVEL = 0
) (
    input logic    clk,
    input logic    rst,
    piso_if.slave  bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             frame_done_q, frame_done_d;
    logic             tc, step, last, accept;
    assign step   = state_q == SHIFT && bus.shift_en;
    assign last   = step && tc;
    assign bus.load_ready = state_q == IDLE || last;
    assign accept = bus.load_valid && bus.load_ready;
    always_comb begin
        shreg_d      = accept ? bus.load_data
                     : step   ? (MSB_FIRST ? shreg_q << 1 : shreg_q >> 1)
                     : shreg_q;
        state_d      = accept ? SHIFT : last ? IDLE : state_q;
        frame_done_d = last;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            frame_done_q <= frame_done_d;
        end
    end
    piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (step),
        .clr (accept || last),
        .tc  (tc)
    );
    assign bus.ser_out    = state_q == SHIFT ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_LEVEL;
    assign bus.ser_valid  = state_q == SHIFT;
    assign bus.busy       = state_q == SHIFT;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: vector table, directed corner sequences and random model-checked traffic
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piso_if #(4) if4m ();
    piso_if #(4) if4l ();
    piso_if #(8) if8 ();
    piso_if #(1) if1 ();

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut4m (.clk(clk), .rst(rst), .bus(if4m.slave));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut4l (.clk(clk), .rst(rst), .bus(if4l.slave));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    piso_serializer #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // reference for the 8-bit MSB-first instance: frame position (-1 = idle) and held word
    int         m_pos = -1;
    logic [7:0] m_word = '0;
    logic       m_done = 1'b0;
    logic       sent_q[$];
    int         n_done8 = 0;

    task automatic step8(input logic r, input logic lv, input logic [7:0] d, input logic se);
        logic busy_e, rdy_e, out_e;
        rst = r;
        if8.load_valid = lv;
        if8.load_data  = d;
        if8.shift_en   = se;
        #1;
        busy_e = m_pos >= 0;
        rdy_e  = !busy_e || (m_pos == 7 && se);
        out_e  = busy_e ? m_word[7 - m_pos] : 1'b1;
        chk("w8_ready", if8.load_ready, rdy_e);
        chk("w8_ser_out", if8.ser_out, out_e);
        chk("w8_ser_valid", if8.ser_valid, busy_e);
        chk("w8_busy", if8.busy, busy_e);
        chk("w8_frame_done", if8.frame_done, m_done);
        if (if8.frame_done) n_done8++;
        if (if8.ser_valid && se) sent_q.push_back(if8.ser_out);
        if (r) begin
            m_pos  = -1;
            m_done = 1'b0;
        end else begin
            m_done = busy_e && se && m_pos == 7;
            if (lv && rdy_e) begin
                m_word = d;
                m_pos  = 0;
            end else if (busy_e && se) begin
                m_pos = (m_pos == 7) ? -1 : m_pos + 1;
            end
        end
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] sent_bits();
        logic [15:0] v = '0;
        foreach (sent_q[i]) v = {v[14:0], sent_q[i]};
        return v;
    endfunction

    typedef struct {
        logic       lv;
        logic [3:0] d;
        logic       se;
        logic       rdy;
        logic       so;
        logic       sv;
        logic       fd;
    } vec_t;
    vec_t tbl[7];

    initial begin
        logic [3:0] w4;
        logic       lv1[6], d1[6], so1[6], sv1[6], fd1[6];
        int         nd;
        tbl[0] = '{1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        {if4m.load_valid, if4m.load_data, if4m.shift_en} = '0;
        {if4l.load_valid, if4l.load_data, if4l.shift_en} = '0;
        {if8.load_valid, if8.load_data, if8.shift_en}    = '0;
        {if1.load_valid, if1.load_data, if1.shift_en}    = '0;
        rst = 1'b1;
        tick();
        chk("rst_ready", if8.load_ready, 1'b1);
        chk("rst_ser_out", if8.ser_out, 1'b1);
        chk("rst_ser_valid", if8.ser_valid, 1'b0);
        chk("rst_busy", if8.busy, 1'b0);
        chk("rst_frame_done", if8.frame_done, 1'b0);
        chk("rst_ser_out_w4", if4m.ser_out, 1'b0);
        rst = 1'b0;

        // 4-bit MSB-first frame 1011 with shift_en held high
        foreach (tbl[i]) begin
            if4m.load_valid = tbl[i].lv;
            if4m.load_data  = tbl[i].d;
            if4m.shift_en   = tbl[i].se;
            #1;
            chk($sformatf("msb4_ready[%0d]", i), if4m.load_ready, tbl[i].rdy);
            chk($sformatf("msb4_ser_out[%0d]", i), if4m.ser_out, tbl[i].so);
            chk($sformatf("msb4_ser_valid[%0d]", i), if4m.ser_valid, tbl[i].sv);
            chk($sformatf("msb4_done[%0d]", i), if4m.frame_done, tbl[i].fd);
            tick();
        end
        if4m.shift_en = 1'b0;

        // 4-bit LSB-first frame 1011 with shift_en toggling: each bit held two cycles
        w4 = 4'b1011;
        if4l.load_valid = 1'b1;
        if4l.load_data  = w4;
        if4l.shift_en   = 1'b1;
        #1;
        tick();
        if4l.load_valid = 1'b0;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            if4l.shift_en = k[0];
            #1;
            if (k < 8) chk($sformatf("lsb4_ser_out[%0d]", k), if4l.ser_out, w4[k/2]);
            chk($sformatf("lsb4_ser_valid[%0d]", k), if4l.ser_valid, k < 8);
            chk($sformatf("lsb4_done[%0d]", k), if4l.frame_done, k == 8);
            if (if4l.frame_done) nd++;
            tick();
        end
        chk("lsb4_done_count", nd, 1);
        if4l.shift_en = 1'b0;

        // WIDTH=1 back-to-back words 1,0,1
        lv1 = '{1, 1, 1, 0, 0, 0};
        d1  = '{1, 0, 1, 0, 0, 0};
        so1 = '{0, 1, 0, 1, 0, 0};
        sv1 = '{0, 1, 1, 1, 0, 0};
        fd1 = '{0, 0, 1, 1, 1, 0};
        for (int k = 0; k < 6; k++) begin
            if1.load_valid = lv1[k];
            if1.load_data  = d1[k];
            if1.shift_en   = 1'b1;
            #1;
            chk($sformatf("w1_ready[%0d]", k), if1.load_ready, 1'b1);
            chk($sformatf("w1_ser_out[%0d]", k), if1.ser_out, so1[k]);
            chk($sformatf("w1_ser_valid[%0d]", k), if1.ser_valid, sv1[k]);
            chk($sformatf("w1_done[%0d]", k), if1.frame_done, fd1[k]);
            tick();
        end
        if1.shift_en = 1'b0;

        // A5 then 3C offered in the last-bit cycle: 16 contiguous bits
        sent_q.delete();
        n_done8 = 0;
        step8(0, 1, 8'hA5, 1);
        for (int k = 0; k < 7; k++) step8(0, 0, 8'h00, 1);
        step8(0, 1, 8'h3C, 1);
        for (int k = 0; k < 8; k++) step8(0, 0, 8'h00, 1);
        step8(0, 0, 8'h00, 1);
        step8(0, 0, 8'h00, 1);
        chk("b2b_bit_count", sent_q.size(), 16);
        chk("b2b_bits", sent_bits(), 16'hA53C);
        chk("b2b_done_count", n_done8, 2);

        // load_valid held high with changing data: back-pressure until last-bit cycle
        for (int k = 0; k < 24; k++) step8(0, 1, 8'($urandom), 1);
        for (int k = 0; k < 10; k++) step8(0, 0, 8'h00, 1);

        // reset after three bits aborts the frame, then FF sends eight ones
        step8(0, 1, 8'h5A, 1);
        for (int k = 0; k < 3; k++) step8(0, 0, 8'h00, 1);
        n_done8 = 0;
        step8(1, 1, 8'h00, 1);
        chk("abort_ser_out", if8.ser_out, 1'b1);
        chk("abort_busy", if8.busy, 1'b0);
        sent_q.delete();
        step8(0, 1, 8'hFF, 1);
        for (int k = 0; k < 10; k++) step8(0, 0, 8'h00, 1);
        chk("abort_done_count", n_done8, 1);
        chk("ff_bit_count", sent_q.size(), 8);
        chk("ff_bits", sent_bits(), 16'h00FF);

        // random traffic against the reference
        for (int k = 0; k < 400; k++)
            step8($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
